// File: rtl/div47_seq_radix64.sv
// Sequential radix-64 divider by a constant: retires one 6-bit dividend digit per cycle, MSB first.
// Optional DIV47_SEQ_BACK_TO_BACK_EN lets a new dividend be accepted during the output handshake.
module div47_seq_radix64 #(
  parameter int unsigned WIDTH   = 48,
  parameter int unsigned DIGIT   = 6,
  parameter int unsigned DIVISOR = 47,
  parameter int unsigned RW      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [RW-1:0]    out_remainder,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned TW   = RW + DIGIT;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] digit;
  logic [DIGIT-1:0] qd;
  logic [TW-1:0]    t;
  logic [TW-1:0]    t_rem;
  logic [RW-1:0]    rd;
  logic             accept;

  assign digit = dvd_q[WIDTH-1 -: DIGIT];
  assign t     = {rem_q, digit};

  // Restoring compare-subtract ladder: t < DIVISOR * 2^DIGIT, so DIGIT steps give an exact qd.
  always_comb begin
    t_rem = t;
    qd    = '0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      if (t_rem >= (TW'(DIVISOR) << i)) begin
        t_rem = t_rem - (TW'(DIVISOR) << i);
        qd[i] = 1'b1;
      end
    end
    rd = t_rem[RW-1:0];
  end

`ifdef DIV47_SEQ_BACK_TO_BACK_EN
  assign in_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
`else
  assign in_ready = rst_n & (state_q == StIdle);
`endif

  assign accept        = in_valid & in_ready;
  assign out_valid     = (state_q == StDone);
  assign busy          = (state_q == StRun);
  assign out_quotient  = quo_q;
  assign out_remainder = rem_q;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dvd_d   = in_dividend;
          rem_d   = '0;
          cnt_d   = CW'(NDIG - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        quo_d = (quo_q << DIGIT) | WIDTH'(qd);
        dvd_d = dvd_q << DIGIT;
        rem_d = rd;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          // accept can only be set here when back-to-back mode is compiled in
          if (accept) begin
            dvd_d   = in_dividend;
            rem_d   = '0;
            cnt_d   = CW'(NDIG - 1);
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_div47_seq_radix64.sv
// Randomized self-checking bench for div47_seq_radix64 against plain integer division by 47.
// Result spacing expectation follows DIV47_SEQ_BACK_TO_BACK_EN when the bench is built with it.
module tb_div47_seq_radix64;

`ifdef DIV47_SEQ_BACK_TO_BACK_EN
  localparam int Spacing = 9;
`else
  localparam int Spacing = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_dividend;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_quotient;
  logic [5:0]  out_remainder;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div47_seq_radix64 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] x;
    x = {$urandom, $urandom};
    return x[47:0];
  endfunction

  // Stream-phase scoreboard: accepted dividends queue up, each output handshake pops one.
  logic        stream_en = 1'b0;
  logic [47:0] exp_q[$];
  int          got = 0;
  int          ncyc = 0;
  int          last_hs = -1;

  always @(negedge clk) begin
    ncyc++;
    if (stream_en) begin
      if (in_valid && in_ready) exp_q.push_back(in_dividend);
      if (out_valid && out_ready) begin
        logic [47:0] d;
        if (exp_q.size() == 0) begin
          check("stream_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          d = exp_q.pop_front();
          check("stream_q", 64'(out_quotient), 64'(d / 48'd47));
          check("stream_r", 64'(out_remainder), 64'(d % 48'd47));
        end
        if (last_hs >= 0) check("stream_spacing", 64'(ncyc - last_hs), 64'(Spacing));
        last_hs = ncyc;
        got++;
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_dividend = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_q", 64'(out_quotient), 64'd0);
    check("rst_r", 64'(out_remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_q", 64'(out_quotient), 64'd0);
  endtask

  // One transaction; hold > 0 keeps out_ready low in DONE while offering another dividend.
  task automatic run_one(input logic [47:0] dvd, input int hold);
    int          lat;
    logic [47:0] eq;
    logic [5:0]  er;
    eq = dvd / 48'd47;
    er = 6'(dvd % 48'd47);
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = dvd;
    out_ready   = 1'b0;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("offer_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);  // accept edge (edge 0)
    #1;
    in_valid    = 1'b0;
    in_dividend = rnd48();
    check("run_busy", 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // out_valid appears after edge 8, i.e. the 9th edge counting the accept edge
    check("latency", 64'(lat), 64'd8);
    check("quotient", 64'(out_quotient), 64'(eq));
    check("remainder", 64'(out_remainder), 64'(er));
    if (hold > 0) begin
      in_valid    = 1'b1;
      in_dividend = rnd48();
      repeat (hold) @(posedge clk);
      #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd0);
      check("bp_q_stable", 64'(out_quotient), 64'(eq));
      check("bp_r_stable", 64'(out_remainder), 64'(er));
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    check("idle_q_held", 64'(out_quotient), 64'(eq));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   guard;
    int   sent;
    logic seen;

    do_reset();

    run_one(48'hFFFF_FFFF_FFFF, 0);
    check("max_q_const", 64'(out_quotient), 64'd5988829291716);
    check("max_r_const", 64'(out_remainder), 64'd3);
    run_one(48'd47000, 0);
    run_one(48'd46, 0);
    run_one(48'd0, 0);
    run_one(48'd47, 0);
    run_one(rnd48(), 20);
    for (int i = 0; i < 8; i++) run_one(rnd48(), 0);

    // Abort during the 4th RUN cycle
    @(negedge clk);
    in_valid    = 1'b1;
    in_dividend = rnd48();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    run_one(48'd94, 0);
    check("fresh_94_q", 64'(out_quotient), 64'd2);

    // Streaming with both handshakes held high
    @(negedge clk);
    stream_en   = 1'b1;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    in_dividend = rnd48();
    sent  = 0;
    guard = 0;
    while (sent < 100 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        @(posedge clk);
        #1;
        sent++;
        in_dividend = rnd48();
        if (sent == 100) in_valid = 1'b0;
      end
    end
    guard = 0;
    while (got < 100 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("stream_count", 64'(got), 64'd100);
    stream_en = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
